// File: rtl/sb_spram256ka.sv
// rtl/sb_spram256ka.sv - 16K x 16 single-port synchronous RAM with nibble write mask and low-power controls
module sb_spram256ka (
    input  logic        CLOCK,
    input  logic        reset_n,
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem [0:16383];
    logic [15:0] dout_q;
    logic [15:0] bit_mask;
    logic [15:0] rd_word;
    logic [15:0] wr_word;
    logic        active;

    // POWEROFF is active-low: 1 means powered and usable
    assign active   = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;
    assign bit_mask = {{4{MASKWREN[3]}}, {4{MASKWREN[2]}},
                       {4{MASKWREN[1]}}, {4{MASKWREN[0]}}};
    assign rd_word  = mem[ADDRESS];
    assign wr_word  = (DATAIN & bit_mask) | (rd_word & ~bit_mask);

    // Memory array has no reset; writes are simply suppressed while reset_n is low
    always_ff @(posedge CLOCK) begin
        if (reset_n && active && WREN) begin
            mem[ADDRESS] <= wr_word;
        end
    end

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= 16'h0000;
        end else if (active && !WREN) begin
            dout_q <= rd_word;
        end
    end

    // Sleep and power-off mask the output without disturbing the held read data
    assign DATAOUT = (SLEEP || !POWEROFF) ? 16'h0000 : dout_q;

endmodule

// File: tb/tb_sb_spram256ka.sv
// tb/tb_sb_spram256ka.sv - scoreboard bench for sb_spram256ka against a behavioural RAM model
module tb_sb_spram256ka;

    logic        CLOCK = 1'b0;
    logic        reset_n;
    logic [13:0] ADDRESS;
    logic [15:0] DATAIN;
    logic [3:0]  MASKWREN;
    logic        WREN;
    logic        CHIPSELECT;
    logic        STANDBY;
    logic        SLEEP;
    logic        POWEROFF;
    logic [15:0] DATAOUT;

    sb_spram256ka dut (
        .CLOCK      (CLOCK),
        .reset_n    (reset_n),
        .ADDRESS    (ADDRESS),
        .DATAIN     (DATAIN),
        .MASKWREN   (MASKWREN),
        .WREN       (WREN),
        .CHIPSELECT (CHIPSELECT),
        .STANDBY    (STANDBY),
        .SLEEP      (SLEEP),
        .POWEROFF   (POWEROFF),
        .DATAOUT    (DATAOUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [16384];
    logic [15:0] ref_dout;
    logic [13:0] sweep[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check the combinational view, advance the model, queue the post-edge value
    task automatic cyc(input string name, input bit rst_b, input logic [13:0] a, input logic [15:0] d,
                       input logic [3:0] m, input bit we, input bit cs, input bit sb, input bit sl, input bit po);
        logic [15:0] shown;
        @(negedge CLOCK);
        reset_n = rst_b; ADDRESS = a; DATAIN = d; MASKWREN = m;
        WREN = we; CHIPSELECT = cs; STANDBY = sb; SLEEP = sl; POWEROFF = po;
        if (!rst_b) ref_dout = 16'h0000;
        shown = (sl || !po) ? 16'h0000 : ref_dout;
        #1 check({name, "_comb"}, DATAOUT, shown);
        if (rst_b && po && !sl && !sb && cs) begin
            if (we) begin
                for (int n = 0; n < 4; n++)
                    if (m[n]) ref_mem[a][4*n +: 4] = d[4*n +: 4];
            end else begin
                ref_dout = ref_mem[a];
            end
        end
        exp_q.push_back('{(sl || !po) ? 16'h0000 : ref_dout, name});
    endtask

    task automatic wr(input string name, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        cyc(name, 1'b1, a, d, m, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rd(input string name, input logic [13:0] a);
        cyc(name, 1'b1, a, 16'($urandom), 4'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, DATAOUT, e.val);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [13:0] a;
        logic [13:0] tmp;
        int          j;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
        ref_dout = 16'h0000;
        reset_n = 1'b0; ADDRESS = '0; DATAIN = '0; MASKWREN = '0;
        WREN = 1'b0; CHIPSELECT = 1'b0; STANDBY = 1'b0; SLEEP = 1'b0; POWEROFF = 1'b1;
        #12 check("reset_dataout", DATAOUT, 16'h0000);
        cyc("release", 1'b1, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        wr("full_wr_lo", 14'h0000, 16'hA5C3, 4'hF);
        wr("full_wr_hi", 14'h3FFF, 16'h3C5A, 4'hF);
        rd("full_rd_lo", 14'h0000);
        rd("full_rd_hi", 14'h3FFF);

        wr("mask_pre", 14'h0123, 16'hFFFF, 4'hF);
        wr("mask_lo", 14'h0123, 16'h1234, 4'h3);
        rd("mask_rd_ff34", 14'h0123);
        wr("mask_hi", 14'h0123, 16'hABCD, 4'hC);
        rd("mask_rd_ab34", 14'h0123);
        wr("mask_none", 14'h0123, 16'h0000, 4'h0);
        rd("mask_rd_none", 14'h0123);

        wr("cs_pre", 14'h0010, 16'h5555, 4'hF);
        cyc("cs_off_wr", 1'b1, 14'h0010, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rd("cs_rd", 14'h0010);
        cyc("stby_wr", 1'b1, 14'h0010, 16'h0000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("stby_rd_hold", 1'b1, 14'h0123, 16'h0000, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        rd("stby_rd", 14'h0010);

        wr("sleep_pre", 14'h0200, 16'hBEEF, 4'hF);
        rd("sleep_rd", 14'h0200);
        cyc("sleep_wr", 1'b1, 14'h0200, 16'h0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("sleep_idle", 1'b1, 14'h0010, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("sleep_exit", 1'b1, 14'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rd("sleep_mem", 14'h0200);

        wr("rst_pre", 14'h0300, 16'h1234, 4'hF);
        rd("rst_rd", 14'h0300);
        @(posedge CLOCK);
        #3 reset_n = 1'b0;
        ref_dout = 16'h0000;
        #1 check("rst_async", DATAOUT, 16'h0000);
        reset_n = 1'b1;
        cyc("rst_held_wr", 1'b0, 14'h0300, 16'h0000, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        rd("rst_mem", 14'h0300);

        for (int i = 0; i < 256; i++) begin
            a = 14'($urandom);
            sweep.push_back(a);
            wr("sweep_wr", a, 16'(a) * 16'd3, 4'hF);
        end
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = sweep[i]; sweep[i] = sweep[j]; sweep[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            rd("sweep_rd", sweep[i]);
            if ($urandom_range(0, 3) == 0)
                wr("sweep_gap_wr", sweep[$urandom_range(0, 255)], 16'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'b1, sweep[$urandom_range(0, 255)], 16'($urandom), 4'($urandom),
                1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, 1'b1);
        end

        rd("pwr_pre", 14'h0000);
        cyc("pwr_off", 1'b1, 14'h3FFF, 16'h0000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("pwr_off_sleep", 1'b1, 14'h3FFF, 16'h0000, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("pwr_on", 1'b1, 14'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wr("pwr_wr", 14'h0040, 16'h6C93, 4'hF);
        rd("pwr_rd", 14'h0040);

        cyc("drain", 1'b1, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge CLOCK);
        #3 check("queue_empty", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_spram256ka.md
# sb_spram256ka

Single-port 16384 x 16-bit synchronous RAM, behaviourally equivalent to the iCE40 UltraPlus SPRAM primitive. It is the storage element behind the frame buffer: four instances form a 64K x 16 (128 KB) array, with byte lanes selected through the nibble write mask. It provides one shared address port for reads and writes, nibble-granular write enables, registered read data, and low-power controls.

## Interface
- No parameters. Depth is fixed at 16384 words and width at 16 bits.
- CLOCK  input  1  single clock; all accesses are sampled on its rising edge.
- reset_n  input  1  asynchronous active-low reset; clears the DATAOUT register only.
- ADDRESS  input  14  word address, 0..16383.
- DATAIN  input  16  write data.
- MASKWREN  input  4  nibble write enables: bit0 -> [3:0], bit1 -> [7:4], bit2 -> [11:8], bit3 -> [15:12].
- WREN  input  1  1 = write cycle, 0 = read cycle.
- CHIPSELECT  input  1  1 = access enabled.
- STANDBY  input  1  1 = standby; no access, contents retained.
- SLEEP  input  1  1 = sleep; no access, contents retained, DATAOUT forced to 0.
- POWEROFF  input  1  active-LOW power-off; 0 = powered off, 1 = normal.
- DATAOUT  output  16  registered read data.

## Operation
- Active condition: active = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF.
- Write (active & WREN):
  - At the rising edge, each nibble n with MASKWREN[n]=1 takes DATAIN's nibble n.
  - Nibbles with MASKWREN[n]=0 keep their old value.
  - MASKWREN=0000 is a legal no-op write.
  - DATAOUT holds its previous value (no write-through).
- Read (active & ~WREN): at the rising edge, DATAOUT <= mem[ADDRESS]. MASKWREN is ignored.
- Not active (CHIPSELECT=0 or STANDBY=1):
  - No memory change.
  - DATAOUT holds.
- SLEEP=1 or POWEROFF=0:
  - DATAOUT is driven to 0 combinationally, overriding the register.
  - The register keeps its value and reappears when the condition is removed.
- Power-off contents:
  - After any cycle with POWEROFF=0, memory contents are undefined.
  - The model leaves them unchanged, but the bench must not check them.
- Priority when several controls are asserted: POWEROFF=0 > SLEEP > STANDBY > CHIPSELECT=0.
- Memory is not cleared by reset. The simulation model initialises all words to 0.
- ADDRESS is always in range (14 bits); there is no wrap or overflow case.

## Timing
- Read latency: 1 cycle. Address presented before edge k gives data on DATAOUT after edge k, stable until the next read edge.
- Write takes effect at the edge.
  - A read of the same address on the next cycle returns the new data.
  - Back-to-back write then read of the same address needs no bubble.
- Read-during-write is impossible (single port).
- Reset:
  - reset_n=0 clears the DATAOUT register to 0 immediately, independent of CLOCK.
  - Writes and reads are blocked while reset_n=0.
  - The first access is on the first rising edge after release.
- Reset value of every output: DATAOUT = 16'h0000.
- Reset asserted mid-access: the access in the current cycle is dropped; memory is unchanged if the edge has not yet occurred.
- Low-power exit:
  - Leaving SLEEP, STANDBY, or power-off needs no wait cycles in the model.
  - The next edge with active=1 performs the access.

## Test plan
- Full write/read: write 16'hA5C3 to 0x0000 and 16'h3C5A to 0x3FFF with MASKWREN=1111, then read both -> DATAOUT=A5C3, then 3C5A, each one edge after its address.
- Nibble mask: preload 0x0123 with 16'hFFFF, write 16'h1234 with MASKWREN=0011 -> read gives 16'hFF34. Then write 16'hABCD with MASKWREN=1100 -> read gives 16'hAB34.
- Chip select and standby:
  - Write 16'h0000 to 0x0010 with CHIPSELECT=0 -> no change; a read returns the prior value 16'h5555.
  - The same write with STANDBY=1 -> no change.
  - During both, DATAOUT holds its last value.
- Sleep: after a read of 16'hBEEF, assert SLEEP -> DATAOUT=0 immediately. A write attempt is ignored. Deassert SLEEP -> DATAOUT=BEEF again, and a memory read still returns the original data.
- Reset: read 16'h1234, then pulse reset_n low mid-cycle -> DATAOUT=0 before the next edge. After release, a read returns 16'h1234 (memory intact).
- Write-then-read sweep: write addr*3 (mod 2^16) to 256 random addresses with a full mask, then read them back in random order -> every value matches at 1-cycle latency. A write cycle between reads does not disturb DATAOUT.
